// File: rtl/interrupt_controller.sv
// 8259-style interrupt controller: eight edge-triggered request lines, fully nested priority,
// two-pulse INTA vector. Define PIC_AUTO_EOI_EN to honour the ICW4 auto-EOI bit.
module interrupt_controller #(
  parameter logic [7:0] RESET_BASE = 8'h08
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iCs,
  input  logic       iA0,
  input  logic       iIOW,
  input  logic       iIOR,
  input  logic [7:0] iData,
  input  logic [7:0] iIrq,
  input  logic       iIntA_n,
  output logic       oInt,
  output logic [7:0] oData,
  output logic       oDataEn
);

  typedef enum logic [2:0] {S_UNINIT, S_ICW2, S_ICW3, S_ICW4, S_READY} state_t;

  state_t     state_q, state_d;
  logic       prev_w_q, prev_r_q, prev_inta_q;
  logic [7:0] prev_irq_q;
  logic [7:0] irr_q, irr_d, isr_q, isr_d, imr_q, imr_d;
  logic [4:0] base_q, base_d;
  logic       sngl_q, sngl_d, ic4_q, ic4_d, rsel_q, rsel_d;
  logic       cnt_q, cnt_d, vec_q, vec_d, spur_q, spur_d;
  logic [2:0] lvl_q, lvl_d;
  logic       int_q, int_d, den_q, den_d;
  logic [7:0] data_q, data_d;
  logic       aeoi;

  logic       wr_ev, rd_ev, icw1, inta_fall, inta_rise;
  logic [7:0] irq_rise, pend, elig;
  logic [2:0] top_elig, top_isr;
  logic       any_elig;

  assign wr_ev     = iIOW & iCs & ~prev_w_q;
  assign rd_ev     = iIOR & iCs & ~prev_r_q;
  assign icw1      = wr_ev & ~iA0 & iData[4];
  assign inta_fall = prev_inta_q & ~iIntA_n;
  assign inta_rise = ~prev_inta_q & iIntA_n;
  assign irq_rise  = iIrq & ~prev_irq_q;
  assign pend      = irr_q & ~imr_q;

  // Fully nested: any in-service level at or above j blocks level j.
  for (genvar gi = 0; gi < 8; gi++) begin : g_elig
    assign elig[gi] = pend[gi] & ~(|isr_q[gi:0]);
  end
  assign any_elig = |elig;

  always_comb begin
    top_elig = 3'd0;
    top_isr  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (elig[i]) top_elig = 3'(i);
      if (isr_q[i]) top_isr = 3'(i);
    end
  end

`ifdef PIC_AUTO_EOI_EN
  logic aeoi_q, aeoi_d;
  assign aeoi = aeoi_q;
  always_ff @(posedge iClk) begin
    if (iRst) aeoi_q <= 1'b0;
    else      aeoi_q <= aeoi_d;
  end
  always_comb begin
    aeoi_d = aeoi_q;
    if (!icw1 && wr_ev && iA0 && state_q == S_ICW4) aeoi_d = iData[1];
  end
`else
  assign aeoi = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    irr_d   = irr_q | irq_rise;
    isr_d   = isr_q;
    imr_d   = imr_q;
    base_d  = base_q;
    sngl_d  = sngl_q;
    ic4_d   = ic4_q;
    rsel_d  = rsel_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    lvl_d   = lvl_q;
    spur_d  = spur_q;
    data_d  = data_q;

    // Acknowledge: the clear of IRR[L] overrides a coincident new request edge.
    if (inta_fall && !cnt_q) begin
      cnt_d = 1'b1;
      if (any_elig) begin
        lvl_d           = top_elig;
        spur_d          = 1'b0;
        isr_d[top_elig] = 1'b1;
        irr_d[top_elig] = 1'b0;
      end else begin
        lvl_d  = 3'd7;
        spur_d = 1'b1;
      end
    end else if (inta_fall && cnt_q) begin
      vec_d  = 1'b1;
      data_d = {base_q, lvl_q};
    end else if (inta_rise && vec_q) begin
      cnt_d = 1'b0;
      vec_d = 1'b0;
      if (aeoi && !spur_q) isr_d[lvl_q] = 1'b0;
    end

    if (icw1) begin
      state_d = S_ICW2;
      imr_d   = 8'h00;
      isr_d   = 8'h00;
      irr_d   = 8'h00;
      sngl_d  = iData[1];
      ic4_d   = iData[0];
    end else if (wr_ev) begin
      case (state_q)
        S_ICW2: if (iA0) begin
          base_d = iData[7:3];
          if (!sngl_q)    state_d = S_ICW3;
          else if (ic4_q) state_d = S_ICW4;
          else            state_d = S_READY;
        end
        S_ICW3: if (iA0) state_d = ic4_q ? S_ICW4 : S_READY;
        S_ICW4: if (iA0) state_d = S_READY;
        S_READY: begin
          if (iA0) begin
            imr_d = iData;
          end else if (!iData[3]) begin
            case (iData[7:5])
              3'b001:  if (|isr_q) isr_d[top_isr] = 1'b0;
              3'b011:  isr_d[iData[2:0]] = 1'b0;
              default: ;
            endcase
          end else if (iData[1]) begin
            rsel_d = iData[0];
          end
        end
        default: ;
      endcase
    end

    if (rd_ev && !vec_d) data_d = iA0 ? imr_q : (rsel_q ? isr_q : irr_q);
    den_d = vec_d | (iIOR & iCs);
    int_d = (state_q == S_READY) & any_elig;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= S_UNINIT;
      prev_w_q    <= 1'b1;
      prev_r_q    <= 1'b1;
      prev_inta_q <= 1'b0;
      prev_irq_q  <= 8'h00;
      irr_q       <= 8'h00;
      isr_q       <= 8'h00;
      imr_q       <= 8'h00;
      base_q      <= RESET_BASE[7:3];
      sngl_q      <= 1'b0;
      ic4_q       <= 1'b0;
      rsel_q      <= 1'b0;
      cnt_q       <= 1'b0;
      vec_q       <= 1'b0;
      lvl_q       <= 3'd0;
      spur_q      <= 1'b0;
      int_q       <= 1'b0;
      den_q       <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      prev_w_q    <= iIOW;
      prev_r_q    <= iIOR;
      prev_inta_q <= iIntA_n;
      prev_irq_q  <= iIrq;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      imr_q       <= imr_d;
      base_q      <= base_d;
      sngl_q      <= sngl_d;
      ic4_q       <= ic4_d;
      rsel_q      <= rsel_d;
      cnt_q       <= cnt_d;
      vec_q       <= vec_d;
      lvl_q       <= lvl_d;
      spur_q      <= spur_d;
      int_q       <= int_d;
      den_q       <= den_d;
      data_q      <= data_d;
    end
  end

  assign oInt    = int_q;
  assign oData   = data_q;
  assign oDataEn = den_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios plus a randomized
// sequence, all checked against a behavioural model of the controller's register rules.
module tb_interrupt_controller;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic       iCs = 1'b0, iA0 = 1'b0, iIOW = 1'b0, iIOR = 1'b0;
  logic [7:0] iData = 8'h00, iIrq = 8'h00;
  logic       iIntA_n = 1'b1;
  logic       oInt, oDataEn;
  logic [7:0] oData;

  int errors = 0;
  int checks = 0;

  interrupt_controller dut (
    .iClk(iClk), .iRst(iRst), .iCs(iCs), .iA0(iA0), .iIOW(iIOW), .iIOR(iIOR),
    .iData(iData), .iIrq(iIrq), .iIntA_n(iIntA_n),
    .oInt(oInt), .oData(oData), .oDataEn(oDataEn)
  );

  always #5 iClk = ~iClk;

  // Behavioural model: phase 0=uninit 1=want ICW2 2=want ICW3 3=want ICW4 4=ready
  int         m_phase;
  bit         m_sngl, m_ic4, m_rsel, m_aeoi;
  logic [7:0] m_irr, m_isr, m_imr, m_base;

  function automatic void model_reset();
    m_phase = 0; m_sngl = 0; m_ic4 = 0; m_rsel = 0; m_aeoi = 0;
    m_irr = 0; m_isr = 0; m_imr = 0; m_base = 8'h08;
  endfunction

  function automatic int model_best();
    for (int j = 0; j < 8; j++) begin
      if (m_isr[j]) return -1;
      if (m_irr[j] && !m_imr[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic model_int();
    return (m_phase == 4) && (model_best() >= 0);
  endfunction

  function automatic void model_write(input logic a0, input logic [7:0] d);
    if (!a0 && d[4]) begin
      m_imr = 0; m_isr = 0; m_irr = 0; m_sngl = d[1]; m_ic4 = d[0]; m_phase = 1;
    end else if (a0 && m_phase == 1) begin
      m_base  = {d[7:3], 3'b000};
      m_phase = !m_sngl ? 2 : (m_ic4 ? 3 : 4);
    end else if (a0 && m_phase == 2) begin
      m_phase = m_ic4 ? 3 : 4;
    end else if (a0 && m_phase == 3) begin
`ifdef PIC_AUTO_EOI_EN
      m_aeoi = d[1];
`endif
      m_phase = 4;
    end else if (m_phase == 4) begin
      if (a0) m_imr = d;
      else if (!d[3]) begin
        if (d[7:5] == 3'b001) begin
          for (int j = 0; j < 8; j++) if (m_isr[j]) begin m_isr[j] = 1'b0; break; end
        end else if (d[7:5] == 3'b011) begin
          m_isr[d[2:0]] = 1'b0;
        end
      end else if (d[1]) m_rsel = d[0];
    end
  endfunction

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic io_write(input logic a0, input logic [7:0] d);
    iCs = 1; iA0 = a0; iData = d; iIOW = 1;
    tick(); tick(); tick();
    iIOW = 0;
    tick();
    iCs = 0;
    model_write(a0, d);
    $display("%0t write a0=%0d data=%02h", $time, a0, d);
  endtask

  task automatic io_read(input logic a0, output logic [7:0] d, output logic en_hi, output logic en_lo);
    iCs = 1; iA0 = a0; iIOR = 1;
    tick(); tick();
    d = oData; en_hi = oDataEn;
    iIOR = 0;
    tick();
    en_lo = oDataEn;
    iCs = 0;
    $display("%0t read  a0=%0d data=%02h", $time, a0, d);
  endtask

  task automatic pulse_irq(input logic [7:0] m);
    iIrq = m;
    tick();
    iIrq = 0;
    m_irr = m_irr | m;
    $display("%0t irq   mask=%02h", $time, m);
  endtask

  task automatic inta(output logic [7:0] vec, output logic [7:0] exp_vec,
                      output logic en_hi, output logic en_lo);
    int lvl;
    lvl = model_best();
    if (lvl >= 0) begin
      m_isr[lvl] = 1'b1; m_irr[lvl] = 1'b0;
    end
    exp_vec = {m_base[7:3], (lvl >= 0) ? 3'(lvl) : 3'd7};
    iIntA_n = 0; tick(); tick();
    iIntA_n = 1; tick(); tick();
    iIntA_n = 0; tick(); tick();
    vec = oData; en_hi = oDataEn;
    iIntA_n = 1; tick();
    en_lo = oDataEn;
    tick();
    if (m_aeoi && lvl >= 0) m_isr[lvl] = 1'b0;
    $display("%0t inta  vector=%02h", $time, vec);
  endtask

  logic [7:0] rd, vec, ev;
  logic       hi, lo;

  task automatic test_reset();
    iRst = 1; tick(); tick(); tick(); iRst = 0; model_reset(); tick();
    checks++; if (oInt !== 1'b0) begin errors++; $display("FAIL reset_int got=%0b exp=0", oInt); end
    checks++; if (oData !== 8'h00) begin errors++; $display("FAIL reset_data got=%02h exp=00", oData); end
    checks++; if (oDataEn !== 1'b0) begin errors++; $display("FAIL reset_den got=%0b exp=0", oDataEn); end
    io_read(1, rd, hi, lo);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL reset_imr got=%02h exp=00", rd); end
    checks++; if (hi !== 1'b1 || lo !== 1'b0) begin errors++; $display("FAIL read_den got=%0b%0b exp=10", hi, lo); end
  endtask

  task automatic test_uninit_irq();
    pulse_irq(8'h01); tick(); tick();
    checks++; if (oInt !== 1'b0) begin errors++; $display("FAIL uninit_int got=%0b exp=0", oInt); end
    io_read(0, rd, hi, lo);
    checks++; if (rd !== m_irr) begin errors++; $display("FAIL uninit_irr got=%02h exp=%02h", rd, m_irr); end
  endtask

  task automatic test_basic();
    io_write(0, 8'h13); io_write(1, 8'h08); io_write(1, 8'h01); io_write(1, 8'hFE);
    iIrq = 8'h01; tick();
    checks++; if (oInt !== 1'b0) begin errors++; $display("FAIL basic_int_early got=%0b exp=0", oInt); end
    iIrq = 8'h00; m_irr[0] = 1'b1; tick();
    checks++; if (oInt !== 1'b1) begin errors++; $display("FAIL basic_int got=%0b exp=1", oInt); end
    inta(vec, ev, hi, lo);
    checks++; if (vec !== 8'h08) begin errors++; $display("FAIL basic_vec got=%02h exp=08", vec); end
    checks++; if (hi !== 1'b1 || lo !== 1'b0) begin errors++; $display("FAIL basic_vec_den got=%0b%0b exp=10", hi, lo); end
    checks++; if (oInt !== 1'b0) begin errors++; $display("FAIL basic_int_ack got=%0b exp=0", oInt); end
    io_write(0, 8'h0B); io_read(0, rd, hi, lo);
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL basic_isr got=%02h exp=01", rd); end
    io_write(0, 8'h20); io_read(0, rd, hi, lo);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL basic_eoi got=%02h exp=00", rd); end
    io_write(0, 8'h0A);
  endtask

  task automatic test_priority();
    io_write(1, 8'h00);
    pulse_irq(8'h0A); tick();
    checks++; if (oInt !== 1'b1) begin errors++; $display("FAIL prio_int got=%0b exp=1", oInt); end
    inta(vec, ev, hi, lo);
    checks++; if (vec !== 8'h09) begin errors++; $display("FAIL prio_vec1 got=%02h exp=09", vec); end
    tick();
    checks++; if (oInt !== 1'b0) begin errors++; $display("FAIL prio_nested got=%0b exp=0", oInt); end
    io_write(0, 8'h20); tick();
    checks++; if (oInt !== 1'b1) begin errors++; $display("FAIL prio_after_eoi got=%0b exp=1", oInt); end
    inta(vec, ev, hi, lo);
    checks++; if (vec !== 8'h0B) begin errors++; $display("FAIL prio_vec2 got=%02h exp=0B", vec); end
    io_write(0, 8'h20);
  endtask

  task automatic test_mask_reads();
    io_write(1, 8'h04);
    pulse_irq(8'h04); tick(); tick();
    checks++; if (oInt !== 1'b0) begin errors++; $display("FAIL mask_int got=%0b exp=0", oInt); end
    io_read(0, rd, hi, lo);
    checks++; if (rd !== 8'h04) begin errors++; $display("FAIL mask_irr got=%02h exp=04", rd); end
    io_write(0, 8'h0B); io_read(0, rd, hi, lo);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL mask_isr got=%02h exp=00", rd); end
    io_read(1, rd, hi, lo);
    checks++; if (rd !== 8'h04) begin errors++; $display("FAIL mask_imr got=%02h exp=04", rd); end
  endtask

  task automatic test_spurious();
    inta(vec, ev, hi, lo);
    checks++; if (vec !== 8'h0F) begin errors++; $display("FAIL spur_vec got=%02h exp=0F", vec); end
    io_read(0, rd, hi, lo);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL spur_isr got=%02h exp=00", rd); end
    pulse_irq(8'h08); tick();
    inta(vec, ev, hi, lo);
    io_write(1, 8'h00);
    inta(vec, ev, hi, lo);
    checks++; if (vec !== 8'h0A) begin errors++; $display("FAIL spur_vec_ir2 got=%02h exp=0A", vec); end
    io_read(0, rd, hi, lo);
    checks++; if (rd !== 8'h0C) begin errors++; $display("FAIL spur_isr_both got=%02h exp=0C", rd); end
    io_write(0, 8'h63); io_read(0, rd, hi, lo);
    checks++; if (rd !== 8'h04) begin errors++; $display("FAIL spec_eoi got=%02h exp=04", rd); end
    io_write(0, 8'h62); io_write(0, 8'h0A);
  endtask

  task automatic test_aeoi();
    logic [7:0] exp_isr;
`ifdef PIC_AUTO_EOI_EN
    exp_isr = 8'h00;
`else
    exp_isr = 8'h20;
`endif
    io_write(0, 8'h13); io_write(1, 8'h08); io_write(1, 8'h03); io_write(1, 8'h00);
    pulse_irq(8'h20); tick();
    inta(vec, ev, hi, lo);
    checks++; if (vec !== 8'h0D) begin errors++; $display("FAIL aeoi_vec got=%02h exp=0D", vec); end
    io_write(0, 8'h0B); io_read(0, rd, hi, lo);
    checks++; if (rd !== exp_isr) begin errors++; $display("FAIL aeoi_isr got=%02h exp=%02h", rd, exp_isr); end
    io_write(0, 8'h65); io_write(0, 8'h0A);
  endtask

  task automatic test_random();
    logic       a0;
    logic [7:0] m, exp;
    io_write(0, 8'h13); io_write(1, 8'($urandom_range(0, 31) << 3)); io_write(1, 8'h01);
    io_write(1, 8'($urandom));
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          m = 8'($urandom); pulse_irq(m); tick();
        end
        2: begin
          inta(vec, ev, hi, lo);
          checks++; if (vec !== ev || hi !== 1'b1) begin errors++; $display("FAIL rnd_vec it=%0d got=%02h/%0b exp=%02h/1", it, vec, hi, ev); end
        end
        3: begin
          if ($urandom_range(0, 1) == 1) io_write(0, 8'h20);
          else io_write(0, 8'h60 | 8'($urandom_range(0, 7)));
        end
        4: begin
          if ($urandom_range(0, 2) == 0) io_write(1, 8'($urandom));
          else io_write(0, 8'h0A | 8'($urandom_range(0, 1)));
        end
        default: begin
          a0 = 1'($urandom_range(0, 1));
          io_read(a0, rd, hi, lo);
          exp = a0 ? m_imr : (m_rsel ? m_isr : m_irr);
          checks++; if (rd !== exp) begin errors++; $display("FAIL rnd_read it=%0d a0=%0d got=%02h exp=%02h", it, a0, rd, exp); end
        end
      endcase
      tick();
      checks++; if (oInt !== model_int()) begin errors++; $display("FAIL rnd_int it=%0d got=%0b exp=%0b", it, oInt, model_int()); end
    end
  endtask

  task automatic test_reset_mid_inta();
    io_write(0, 8'h13); io_write(1, 8'h08); io_write(1, 8'h01); io_write(1, 8'h00);
    pulse_irq(8'h40); tick();
    iIntA_n = 0; tick(); tick();
    iIntA_n = 1; tick(); tick();
    iIntA_n = 0; tick(); tick();
    checks++; if (oDataEn !== 1'b1) begin errors++; $display("FAIL midack_den_pre got=%0b exp=1", oDataEn); end
    iRst = 1; tick();
    checks++; if (oDataEn !== 1'b0) begin errors++; $display("FAIL midack_den got=%0b exp=0", oDataEn); end
    iRst = 0; model_reset(); tick();
    checks++; if (oInt !== 1'b0 || oData !== 8'h00) begin errors++; $display("FAIL midack_out got=%0b/%02h exp=0/00", oInt, oData); end
    iIntA_n = 1; tick(); tick();
    io_read(0, rd, hi, lo);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL midack_irr got=%02h exp=00", rd); end
    io_write(0, 8'h13); io_write(1, 8'h30); io_write(1, 8'h01); io_write(1, 8'h00);
    pulse_irq(8'h10); tick();
    inta(vec, ev, hi, lo);
    checks++; if (vec !== 8'h34) begin errors++; $display("FAIL midack_next_vec got=%02h exp=34", vec); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_uninit_irq();
    test_basic();
    test_priority();
    test_mask_reads();
    test_spurious();
    test_aeoi();
    test_random();
    test_reset_mid_inta();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

- 8259-style programmable interrupt controller; sits directly upstream of the CPU arbiter.
- Collects eight peripheral interrupt lines and drives the arbiter's `iInt` input.
- Answers the two-pulse 8088 interrupt-acknowledge sequence with a vector byte on the CPU read-data mux.
- Programmed through I/O ports 0x20/0x21; the system decodes these ports into `iCs`/`iA0`.

## Interface
Parameters:
- `RESET_BASE`, 8'h08: vector base loaded into the vector register on `iRst` (ICW2 overrides it).

Ports:
- `iClk`  in  1  system clock, the same clock as the CPU arbiter.
- `iRst`  in  1  reset, synchronous, active-high.
- `iCs`  in  1  port select (0x20/0x21 decoded upstream).
- `iA0`  in  1  port address bit 0.
- `iIOW`  in  1  I/O write strobe, 1 = active, held for many `iClk` cycles.
- `iIOR`  in  1  I/O read strobe, 1 = active.
- `iData`  in  8  CPU write data.
- `iIrq`  in  8  interrupt requests, already synchronous to `iClk`; IR0 has the highest priority.
- `iIntA_n`  in  1  interrupt acknowledge from the arbiter, 0 = acknowledge.
- `oInt`  out  1  interrupt request to the CPU.
- `oData`  out  8  read data / vector byte.
- `oDataEn`  out  1  1 = the system mux selects `oData` for the CPU data input.

## Operation
- **Strobe events.** Each strobe fires once, on its rising edge, using a registered previous value.
  - Write event: `iIOW & iCs & ~prevW`.
  - Read event: `iIOR & iCs & ~prevR`.
- **Init FSM.** States are UNINIT → ICW2 → [ICW3] → [ICW4] → READY.
  - ICW1 is a write with A0=0 and D4=1. It is accepted in any state.
  - ICW1 clears IMR, ISR and IRR, latches SNGL=D1 and IC4=D0, and enters ICW2.
  - ICW2 (A0=1): vector base = D[7:3], low three bits forced to 0.
  - After ICW2: go to ICW3 if SNGL=0, else to ICW4 if IC4=1, else to READY.
  - ICW3 (A0=1): data is discarded; go to ICW4 if IC4, else to READY.
  - ICW4 (A0=1): latch AEOI=D1; go to READY.
  - Writes with A0=0 in states ICW2/ICW3/ICW4 that are not ICW1 are ignored.
- **Operation commands (READY only).**
  - OCW1: write with A0=1 → IMR = D.
  - OCW2: write with A0=0, D4=0, D3=0.
    - D[7:5]=001 (non-specific EOI): clear the highest-priority set ISR bit.
    - D[7:5]=011 (specific EOI): clear ISR[D2:0].
    - All other codes: ignored.
  - OCW3: write with A0=0, D4=0, D3=1. If D1=1, read-select = D0 (0 = IRR, 1 = ISR); if D1=0, read-select is unchanged.
- **Register reads.** A0=0 returns IRR or ISR according to read-select (reset value: IRR). A0=1 returns IMR.
- **IRR.**
  - `IRR[i]` sets on a rising edge of `iIrq[i]` (edge-triggered), regardless of IMR and FSM state.
  - `IRR[i]` clears only when level i is acknowledged, or on ICW1.
- **Eligibility.**
  - `pend = IRR & ~IMR`.
  - Level j is eligible if `pend[j]=1` and no ISR bit k≤j is set (fully nested).
  - `oInt` = READY & (any level eligible), registered.
- **Acknowledge.** The CPU produces two falling edges of `iIntA_n`, counted by a 1-bit counter.
  - First edge: freeze the highest eligible level L, set ISR[L], clear IRR[L].
  - First edge with nothing eligible (spurious): L = 7, ISR unchanged.
  - Second edge: oData = {base[7:3], L}; `oDataEn` = 1 until `iIntA_n` returns high.
  - Second pulse, on its rising edge: the counter returns to 0.
  - Second pulse, on its rising edge, if AEOI is active and the acknowledge was not spurious: clear ISR[L].
- **Mux priority.** An acknowledge read has priority over a register read. `oDataEn` is also asserted while a register read (`iIOR & iCs`) is active.

## Timing
- Reset values:
  - `oInt`=0, `oData`=0, `oDataEn`=0.
  - IMR=0, ISR=0, IRR=0, AEOI=0, base=`RESET_BASE`, read-select=IRR.
  - FSM=UNINIT, INTA counter=0.
- Reset taken mid-acknowledge (during either pulse) aborts the acknowledge; the counter returns to 0.
- `iIrq` rise at edge n: IRR set at edge n+1, `oInt` high at edge n+2.
- First INTA falling edge sampled at edge n: ISR/IRR update at n+1; `oInt` re-evaluated at n+2.
- Register read: `oData`/`oDataEn` valid from the edge after the read event; held while the strobe stays high; `oDataEn` drops 1 cycle after the strobe falls.
- Vector: valid from the edge after the second INTA falling edge; held until `iIntA_n` rises.
- Write effects are visible to reads and to `oInt` evaluation from the edge after the write event.
- Simultaneous IRR edge and acknowledge on the same level: the clear wins; the new edge is lost.

## Configuration
- `PIC_AUTO_EOI_EN` defined: ICW4 D1 is honoured and AEOI clears the ISR bit as described under Acknowledge.
- `PIC_AUTO_EOI_EN` undefined: ICW4 D1 is ignored, AEOI is tied to 0, and software EOI is required.

## Test plan
- Init: ICW1=0x13, ICW2=0x08, ICW4=0x01, OCW1=0xFE; pulse IR0 → `oInt`=1 two cycles later; INTA×2 → vector 0x08, ISR=0x01, `oInt`=0; OCW2=0x20 → ISR=0x00.
- Priority: IR3 and IR1 rise in the same cycle with IMR=0x00 → first vector 0x09. While ISR[1] is set, IR3 remains pending but `oInt`=0; after EOI, `oInt`=1 and the next vector is 0x0B.
- Mask and register reads: IMR=0x04, pulse IR2 → `oInt`=0 and IRR read = 0x04. OCW3=0x0B, then read A0=0 → ISR=0x00. Read A0=1 → 0x04.
- Spurious acknowledge: INTA×2 with nothing pending → vector 0x0F, ISR unchanged. Specific EOI 0x63 clears ISR[3] only.
- Reset during the second INTA pulse → `oDataEn`=0 next cycle and all registers at their reset values. Before any ICW, an IRQ edge leaves `oInt`=0.
- With `PIC_AUTO_EOI_EN`: ICW4=0x03, acknowledge IR5 → ISR=0x00 after the second pulse. Without the macro, the same sequence leaves ISR=0x20.
